// File: rtl/multi_bank_pkt_buf.sv
// ---------------------------------------------------------------------------
// multi_bank_pkt_buf
//
// Single-clock N-bank package buffer between the DAQ_sync pixel stream and the
// Wi-Fi read-out. Incoming bytes are packed into fixed-size packages, one
// package per RAM bank. Only complete (committed) packages are visible to the
// reader. When every bank is occupied, whole incoming packages are dropped so
// that package alignment is never broken.
//
// Ports:
//   sys_clk        in   single clock
//   sys_rst        in   synchronous, active-high reset
//   wr_en          in   din valid this cycle
//   din            in   write data [DATA_WIDTH]
//   wr_abort       in   discard the package currently being written
//   rd_en          in   read request
//   dout           out  registered read data [DATA_WIDTH]
//   valid          out  dout valid
//   pkg_last       out  dout is the last byte of its package
//   package_ready  out  at least one committed package held
//   pkg_count      out  committed packages held [CNT_WIDTH]
//   full           out  pkg_count == BANK_NUM
//   empty          out  pkg_count == 0
//   overflow       out  one-cycle pulse when a package drop starts
//   drop_cnt       out  dropped-package count [DROP_CNT_WIDTH]
//
// Build option:
//   PKT_BUF_DROP_CNT_EN  when defined, drop_cnt is a saturating count of drop
//                        starts (cleared only by sys_rst); otherwise drop_cnt
//                        is tied to zero and no counter exists.
// ---------------------------------------------------------------------------
module multi_bank_pkt_buf #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int PKG_SIZE       = 60,
  parameter  int BANK_NUM       = 4,
  parameter  int DROP_CNT_WIDTH = 16,
  localparam int ADDR_WIDTH     = $clog2(PKG_SIZE),
  localparam int CNT_WIDTH      = $clog2(BANK_NUM + 1)
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic                      wr_en,
  input  logic [DATA_WIDTH-1:0]     din,
  input  logic                      wr_abort,
  input  logic                      rd_en,
  output logic [DATA_WIDTH-1:0]     dout,
  output logic                      valid,
  output logic                      pkg_last,
  output logic                      package_ready,
  output logic [CNT_WIDTH-1:0]      pkg_count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int BANK_W = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(PKG_SIZE - 1);
  localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(BANK_NUM - 1);
  localparam logic [CNT_WIDTH-1:0]  FULL_CNT  = CNT_WIDTH'(BANK_NUM);

  typedef enum logic { WR_FILL, WR_DROP } wr_state_e;
  typedef enum logic { RD_IDLE, RD_READ } rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [DATA_WIDTH-1:0] mem [BANK_NUM][PKG_SIZE];

  logic [BANK_W-1:0]     wb_q, wb_d;
  logic [ADDR_WIDTH-1:0] wi_q, wi_d;
  logic [BANK_W-1:0]     rb_q, rb_d;
  logic [ADDR_WIDTH-1:0] ri_q, ri_d;
  logic [CNT_WIDTH-1:0]  pkg_count_q, pkg_count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  pkg_last_q, pkg_last_d;
  logic                  overflow_q, overflow_d;

  logic has_pkg;
  logic is_full;
  logic drop_start;
  logic mem_we;
  logic commit;
  logic rd_accept;
  logic rel;

  assign has_pkg = (pkg_count_q != '0);
  assign is_full = (pkg_count_q == FULL_CNT);

  // Drop decision looks only at the registered count, so a release on the same
  // edge cannot rescue an incoming package.
  assign drop_start = (wr_state_q == WR_FILL) && wr_en && !wr_abort &&
                      (wi_q == '0) && is_full;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_state_q <= WR_FILL;
      rd_state_q <= RD_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_FILL: if (drop_start) wr_state_d = WR_DROP;
      WR_DROP: begin
        if (wr_abort)                       wr_state_d = WR_FILL;
        else if (wr_en && wi_q == LAST_IDX) wr_state_d = WR_FILL;
      end
      default: wr_state_d = WR_FILL;
    endcase

    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      RD_IDLE: if (rd_en && has_pkg)          rd_state_d = RD_READ;
      RD_READ: if (rd_en && ri_q == LAST_IDX) rd_state_d = RD_IDLE;
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = (wr_state_q == WR_FILL) && wr_en && !wr_abort && !drop_start;
    commit    = mem_we && (wi_q == LAST_IDX);
    rd_accept = rd_en && ((rd_state_q == RD_READ) || has_pkg);
    rel       = rd_accept && (ri_q == LAST_IDX);

    // wi doubles as the discarded-byte counter while dropping; a drop always
    // starts at wi==0, so the plain increment leaves it at 1 after the first
    // discarded byte.
    wi_d = wi_q;
    if (wr_abort) begin
      wi_d = '0;
    end else if (wr_en) begin
      wi_d = (wi_q == LAST_IDX) ? '0 : wi_q + ADDR_WIDTH'(1);
    end

    wb_d = wb_q;
    if (commit) begin
      wb_d = (wb_q == LAST_BANK) ? '0 : wb_q + BANK_W'(1);
    end

    ri_d = ri_q;
    rb_d = rb_q;
    if (rd_accept) begin
      ri_d = (ri_q == LAST_IDX) ? '0 : ri_q + ADDR_WIDTH'(1);
      if (rel) begin
        rb_d = (rb_q == LAST_BANK) ? '0 : rb_q + BANK_W'(1);
      end
    end

    pkg_count_d = pkg_count_q + CNT_WIDTH'(commit) - CNT_WIDTH'(rel);

    dout_d     = rd_accept ? mem[rb_q][ri_q] : dout_q;
    valid_d    = rd_accept;
    pkg_last_d = rel;
    overflow_d = drop_start;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wb_q        <= '0;
      wi_q        <= '0;
      rb_q        <= '0;
      ri_q        <= '0;
      pkg_count_q <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      pkg_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wb_q        <= wb_d;
      wi_q        <= wi_d;
      rb_q        <= rb_d;
      ri_q        <= ri_d;
      pkg_count_q <= pkg_count_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      pkg_last_q  <= pkg_last_d;
      overflow_q  <= overflow_d;
    end
  end

  // Package RAM: no reset, contents are only exposed after a commit.
  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem[wb_q][wi_q] <= din;
    end
  end

`ifdef PKT_BUF_DROP_CNT_EN
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_start && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  assign dout          = dout_q;
  assign valid         = valid_q;
  assign pkg_last      = pkg_last_q;
  assign overflow      = overflow_q;
  assign pkg_count     = pkg_count_q;
  assign package_ready = has_pkg;
  assign full          = is_full;
  assign empty         = !has_pkg;

endmodule
